set_assoc_cache_model: RTL

//  Parametrised N-way set-associative cache tag model: counts hits, misses and evictions for an address stream.

---
 rtl/set_assoc_cache_model.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_cache_model.sv
// set_assoc_cache_model
//   N-way set-associative tag model that measures hit, miss and eviction
//   counts for a stream of byte addresses. Holds tags, valid bits and
//   per-set LRU ages only; no data storage.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           invalidate every line (honoured in IDLE only)
//   req_valid/ready request handshake, req_addr is the byte address
//   resp_valid      one-cycle pulse per accepted request
//   resp_hit        1 = hit, 0 = miss (qualified by resp_valid)
//   resp_way        way that hit or was filled (qualified by resp_valid)
//   hit_count, miss_count, evict_count   saturating statistics
//   dbg_state       current FSM state (0 IDLE, 1 LOOKUP, 2 FILL)
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE with flush low, and
// req_addr must be stable while req_valid is high and req_ready is low.
module set_assoc_cache_model #(
  parameter int ADDR_W       = 32,
  parameter int OFFSET_W     = 6,
  parameter int SETS_LOG2    = 8,
  parameter int WAYS         = 4,
  parameter int MISS_PENALTY = 4,
  parameter int CNT_W        = 32,
  localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  evict_count,
  output logic [1:0]        dbg_state
);

  localparam int SETS  = 1 << SETS_LOG2;
  localparam int TAG_W = ADDR_W - OFFSET_W - SETS_LOG2;
  localparam int PEN_W = $clog2(MISS_PENALTY) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2
  } state_t;

  state_t               state_q;
  logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAY_W-1:0]     age_q   [SETS][WAYS];
  logic [TAG_W-1:0]     req_tag_q;
  logic [SETS_LOG2-1:0] req_idx_q;
  logic [PEN_W-1:0]     fill_cnt_q;

  logic [TAG_W-1:0]     addr_tag;
  logic [SETS_LOG2-1:0] addr_idx;
  logic                 unused_offset;

  assign addr_idx      = req_addr[OFFSET_W+SETS_LOG2-1:OFFSET_W];
  assign addr_tag      = req_addr[ADDR_W-1:OFFSET_W+SETS_LOG2];
  // Offset bits select a byte within the line and never influence lookup.
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  assign req_ready = (state_q == S_IDLE) && !flush;
  assign dbg_state = state_q;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic             victim_valid;
  logic [WAY_W-1:0] max_age;
  logic [WAY_W-1:0] touch_way;
  logic [WAY_W-1:0] age_d [WAYS];

  // Lookup, victim choice and LRU update for the latched set.
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_way   = '0;
    max_age      = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Ages form a permutation, so the oldest way is unique.
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[req_idx_q][w] >= max_age) begin
        max_age    = age_q[req_idx_q][w];
        victim_way = WAY_W'(w);
      end
    end
    // Any invalid way takes priority; scanning downward leaves the lowest.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx_q][w]) victim_way = WAY_W'(w);
    end
    victim_valid = valid_q[req_idx_q][victim_way];

    touch_way = (state_q == S_LOOKUP) ? hit_way : victim_way;
    for (int w = 0; w < WAYS; w++) begin
      age_d[w] = age_q[req_idx_q][w];
      if (age_q[req_idx_q][w] < age_q[req_idx_q][touch_way])
        age_d[w] = age_q[req_idx_q][w] + 1'b1;
      if (WAY_W'(w) == touch_way) age_d[w] = '0;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      evict_count <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      fill_cnt_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end else if (req_valid) begin
            req_tag_q <= addr_tag;
            req_idx_q <= addr_idx;
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            hit_count  <= sat_inc(hit_count);
            for (int w = 0; w < WAYS; w++) age_q[req_idx_q][w] <= age_d[w];
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= hit_way;
            state_q    <= S_IDLE;
          end else begin
            // Nothing is installed until the modelled fill completes.
            fill_cnt_q <= PEN_W'(MISS_PENALTY - 1);
            state_q    <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_cnt_q == '0) begin
            tag_q[req_idx_q][victim_way]   <= req_tag_q;
            valid_q[req_idx_q][victim_way] <= 1'b1;
            for (int w = 0; w < WAYS; w++) age_q[req_idx_q][w] <= age_d[w];
            miss_count <= sat_inc(miss_count);
            if (victim_valid) evict_count <= sat_inc(evict_count);
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_way   <= victim_way;
            state_q    <= S_IDLE;
          end else begin
            fill_cnt_q <= fill_cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
